// File: rtl/seg_pkg.sv
// Shared constants, types and the speed-to-duty helper used by the
// Segway motor drive stage.
package seg_pkg;

    localparam int PWM_W   = 12;
    localparam int PWM_PRD = 4096;

    localparam logic [PWM_W-1:0] ZERO_DUTY = 12'h800;
    localparam logic [PWM_W-1:0] CNT_MAX   = 12'(PWM_PRD - 1);

    typedef logic signed [PWM_W-1:0] spd_t;

    // Offset binary: adding 0x800 mod 4096 is the same as flipping the MSB.
    function automatic logic [PWM_W-1:0] spd2duty(input spd_t spd);
        return {~spd[PWM_W-1], spd[PWM_W-2:0]};
    endfunction

endpackage

// File: rtl/mtr_drv_pwm_dt.sv
// One H-bridge channel: period-boundary duty capture, raw PWM register,
// dead-time counter and registered complementary gate outputs.
module pwm_dt
    import seg_pkg::*;
#(
    parameter int DEAD = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PWM_W-1:0] cnt,
    input  spd_t             spd,
    output logic             PWM1,
    output logic             PWM2
);

    localparam logic [7:0] DEAD_C = 8'(DEAD);

    logic [PWM_W-1:0] duty_q, duty_d;
    logic             sig_q, sig_d;
    logic [7:0]       dcnt_q, dcnt_d;
    logic             pwm1_q, pwm1_d;
    logic             pwm2_q, pwm2_d;
    logic             armed_s;

    // Next-state logic for capture, raw PWM, dead-time and gates.
    always_comb begin
        duty_d  = duty_q;
        sig_d   = 1'b0;
        dcnt_d  = 8'd0;
        armed_s = 1'b0;
        pwm1_d  = 1'b0;
        pwm2_d  = 1'b0;

        if (cnt == CNT_MAX) begin
            duty_d = spd2duty(spd);
        end else begin
            duty_d = duty_q;
        end

        sig_d = (cnt < duty_q);

        // Held at zero while disabled so re-enable always waits a full dead-time.
        if (!en || (sig_d != sig_q)) begin
            dcnt_d = 8'd0;
        end else if (dcnt_q == DEAD_C) begin
            dcnt_d = dcnt_q;
        end else begin
            dcnt_d = dcnt_q + 8'd1;
        end

        armed_s = (dcnt_q == DEAD_C);
        pwm1_d  = en &  sig_q & armed_s;
        pwm2_d  = en & ~sig_q & armed_s;
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= ZERO_DUTY;
            sig_q  <= 1'b0;
            dcnt_q <= 8'd0;
            pwm1_q <= 1'b0;
            pwm2_q <= 1'b0;
        end else begin
            duty_q <= duty_d;
            sig_q  <= sig_d;
            dcnt_q <= dcnt_d;
            pwm1_q <= pwm1_d;
            pwm2_q <= pwm2_d;
        end
    end

    assign PWM1 = pwm1_q;
    assign PWM2 = pwm2_q;

endmodule

// File: rtl/mtr_drv.sv
// Motor drive top: shared 4096-clock period counter and two dead-time
// protected PWM channels for the left and right H-bridges.
module mtr_drv
    import seg_pkg::*;
#(
    parameter int DEAD = 32
) (
    input  logic clk,
    input  logic rst,
    input  spd_t lft_spd,
    input  spd_t rght_spd,
    input  logic en,
    output logic PWM1_lft,
    output logic PWM2_lft,
    output logic PWM1_rght,
    output logic PWM2_rght,
    output logic prd_strt
);

    logic [PWM_W-1:0] cnt_q, cnt_d;

    // Free-running period counter, wraps naturally at 4095.
    always_comb begin
        cnt_d = cnt_q + 12'd1;
    end

    // Period counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 12'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by rst so the pulse is absent while reset is held and appears
    // in the first released cycle, where cnt already reads 0.
    assign prd_strt = (cnt_q == 12'd0) & ~rst;

    pwm_dt #(.DEAD(DEAD)) u_lft (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .cnt  (cnt_q),
        .spd  (lft_spd),
        .PWM1 (PWM1_lft),
        .PWM2 (PWM2_lft)
    );

    pwm_dt #(.DEAD(DEAD)) u_rght (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .cnt  (cnt_q),
        .spd  (rght_spd),
        .PWM1 (PWM1_rght),
        .PWM2 (PWM2_rght)
    );

endmodule
